parity_mem: RTL and testbench
=============================

# parity_mem

Parametrised, parity-protected memory with one write port, one read port and a background scrubber. It is the successor to the fixed 16x4 parity ROM: configurable width and depth, per-lane parity, and a runtime write path. It adds error injection, an error counter, first-error address capture and a scrub state machine that walks the array on idle read cycles. It sits beside datapath lookup tables and buffers that need soft-error detection.

## Interface
- DATA_W, 8: data word width; must be a multiple of LANE_W.
- ADDR_W, 4: address width; depth is 2**ADDR_W.
- LANE_W, 4: bits covered by each parity bit; NLANES = DATA_W/LANE_W.
- PARITY_ODD, 0: 0 selects even parity (p = ^lane); 1 selects odd parity (p = ~^lane).
- CNT_W, 8: error counter width.
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- wr_en, in, 1: write strobe.
- wr_addr, in, ADDR_W: write address.
- wr_data, in, DATA_W: write data.
- inj_err, in, NLANES: with wr_en, inverts the stored parity bit of each set lane.
- rd_en, in, 1: user read request.
- rd_addr, in, ADDR_W: read address.
- rd_valid, out, 1: read response valid.
- rd_data, out, DATA_W: read data.
- rd_err, out, 1: OR of rd_err_lanes.
- rd_err_lanes, out, NLANES: per-lane parity mismatch.
- scrub_en, in, 1: enables background scrubbing.
- scrub_done, out, 1: one-cycle pulse when a full pass completes.
- err_cnt, out, CNT_W: saturating count of detected errors.
- first_err_valid, out, 1: sticky; an error has been captured.
- first_err_addr, out, ADDR_W: address of the first error since the last clear.
- err_clr, in, 1: clears err_cnt, first_err_valid and first_err_addr.

## Operation
- Storage is mem[2**ADDR_W] of DATA_W bits plus par[2**ADDR_W] of NLANES bits.
- Initial contents: mem = 0; par = parity of zero (0 when even, all-ones when odd). reset does not alter the array.
- Write: mem[wr_addr] <= wr_data; par[wr_addr] <= calc(wr_data) ^ inj_err.
- Read port arbitration: a user read has priority. The scrubber issues a read at scrub_addr only in cycles where rd_en=0 and the scrub state is SCAN.
- Check: recompute parity on the data read and compare it with the stored parity, lane by lane. A mismatch in any lane counts as one error event.
- An error event from either a user read or a scrub read increments err_cnt, saturating at 2**CNT_W-1. If first_err_valid=0, it also loads first_err_addr and sets first_err_valid.
- Scrub results never drive rd_valid, rd_data or rd_err*.
- Scrub FSM:
  - IDLE: entered on reset. Moves to SCAN when scrub_en=1.
  - SCAN: issues a read on each idle cycle, then scrub_addr++. When scrub_addr wraps from 2**ADDR_W-1 to 0, scrub_done pulses on the cycle the check of the last address resolves. Moves to IDLE when scrub_en=0; an in-flight check still completes, and scrub_addr is retained so the pass resumes.
- Reset clears scrub_addr to 0.
- Boundary cases:
  - Read and write to the same address in one cycle: read-first; the read returns the old data and old parity.
  - Scrub read and write to the same address in one cycle: the scrub checks the old contents.
  - err_clr coincident with an error event: the event wins. err_cnt=1, first_err_valid=1 and first_err_addr is the new address.
  - err_cnt at saturation stays at saturation until err_clr.
  - Reset mid-pass: the in-flight check is discarded, there is no scrub_done, and the FSM returns to IDLE at scrub_addr=0.

## Timing
- Read latency is 1. rd_en at cycle t gives rd_valid, rd_data and rd_err* registered at t+1.
- rd_valid=0 in every cycle not following a rd_en. rd_data and rd_err* hold their last values while rd_valid=0.
- A write at t is visible to a read issued at t+1.
- Error bookkeeping updates at t+1 for a read issued at t.
- Reset values: rd_valid=0, rd_data=0, rd_err=0, rd_err_lanes=0, scrub_done=0, err_cnt=0, first_err_valid=0, first_err_addr=0, FSM=IDLE.
- With scrub_en=1 and no user traffic, a full pass takes 2**ADDR_W cycles. scrub_done is asserted at cycle 2**ADDR_W after the first scrub read is issued.

## Structure
- Package parity_mem_pkg holds:
  - the calc_parity function, parameterised on LANE_W and PARITY_ODD;
  - the scrub state enum (IDLE, SCAN).
- Sub-module parity_gen: purely combinational, DATA_W in and NLANES parity out. It is instantiated twice: once for the write path and once for the check path.
- The top level holds the arrays, read pipeline register, scrub FSM and error counters.

## Test plan
- Parity compute: DATA_W=8, LANE_W=4, even parity. Write 0xA5 to addr 3, read addr 3 -> rd_valid=1 next cycle, rd_data=0xA5, rd_err=0, err_cnt=0.
- Error injection: write 0x3C to addr 7 with inj_err=2'b10, then read addr 7 -> rd_err_lanes=2'b10, err_cnt=1, first_err_addr=7. A second read of addr 7 -> err_cnt=2, first_err_addr still 7.
- Scrub pass:
  - Stimulus: inject an error at addr 5, inject another at addr 12, then hold scrub_en=1 with no user reads.
  - Response: err_cnt=2, first_err_addr=5, and scrub_done pulses after 16 cycles.
- Arbitration and hazards:
  - During scrub, rd_en on every other cycle -> the pass takes 32 cycles and user reads return correct data.
  - Same-cycle read/write to addr 2 (old 0x11, new 0x22) -> rd_data=0x11.
- Saturation and clear:
  - With CNT_W=2, four error reads -> err_cnt=3.
  - err_clr alone -> all error outputs 0.
  - err_clr together with an error on addr 9 -> err_cnt=1, first_err_addr=9.
- Reset mid-pass: assert reset at scrub_addr=6 -> no scrub_done, FSM=IDLE, all outputs at their reset values, memory contents preserved when read back.

Source files
------------

// File: rtl/parity_mem_pkg.sv
// Shared types and the lane parity helper for the parity-protected memory.
package parity_mem_pkg;

    localparam int LANE_MAX = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scrub_state_t;

    // Lane arrives zero-extended to LANE_MAX; only the low lane_w bits contribute.
    function automatic logic calc_parity(
        input logic [LANE_MAX-1:0] lane,
        input int                  lane_w,
        input bit                  odd
    );
        logic p;
        p = 1'b0;
        for (int i = 0; i < LANE_MAX; i++) begin
            if (i < lane_w) p = p ^ lane[i];
        end
        return p ^ odd;
    endfunction

endpackage

// File: rtl/parity_mem_parity_gen.sv
// Combinational per-lane parity generator.
module parity_gen
    import parity_mem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LANE_W     = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic [DATA_W-1:0]        data,
    output logic [DATA_W/LANE_W-1:0] par
);

    localparam int NLANES = DATA_W / LANE_W;
    localparam bit ODD    = (PARITY_ODD != 0);

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        assign par[l] = calc_parity(LANE_MAX'(data[l*LANE_W +: LANE_W]), LANE_W, ODD);
    end

endmodule

// File: rtl/parity_mem.sv
// Parity-protected 1W/1R memory with error injection, error bookkeeping and a background scrubber.
//
//   state | meaning
//   IDLE  | scrubber parked, scrub_addr retained
//   SCAN  | scrub read issued on every cycle without a user read
module parity_mem
    import parity_mem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int LANE_W     = 4,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/LANE_W-1:0]   inj_err,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_err,
    output logic [DATA_W/LANE_W-1:0]   rd_err_lanes,
    input  logic                       scrub_en,
    output logic                       scrub_done,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       first_err_valid,
    output logic [ADDR_W-1:0]          first_err_addr,
    input  logic                       err_clr
);

    localparam int NLANES = DATA_W / LANE_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    // Parity is stored relative to the parity of zero, so zeroed storage reads back as valid.
    localparam logic [NLANES-1:0] PAR_BIAS = {NLANES{PARITY_ODD != 0}};

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [NLANES-1:0] par_raw [DEPTH];

    logic [NLANES-1:0] wr_par;
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_data;
    logic [NLANES-1:0] port_par;
    logic [NLANES-1:0] chk_par;
    logic [NLANES-1:0] mism;
    logic              err_evt;

    scrub_state_t      state_q, state_d;
    logic              scrub_issue;
    logic [ADDR_W-1:0] scrub_addr;

    parity_gen #(.DATA_W(DATA_W), .LANE_W(LANE_W), .PARITY_ODD(PARITY_ODD)) u_wr_par (
        .data (wr_data),
        .par  (wr_par)
    );

    parity_gen #(.DATA_W(DATA_W), .LANE_W(LANE_W), .PARITY_ODD(PARITY_ODD)) u_chk_par (
        .data (port_data),
        .par  (chk_par)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr]     <= wr_data;
            par_raw[wr_addr] <= wr_par ^ inj_err ^ PAR_BIAS;
        end
    end

    // Single read port: user read wins, scrubber takes idle cycles.
    assign port_addr = rd_en ? rd_addr : scrub_addr;
    assign port_data = mem[port_addr];
    assign port_par  = par_raw[port_addr] ^ PAR_BIAS;
    assign mism      = chk_par ^ port_par;
    assign err_evt   = (rd_en || scrub_issue) && (|mism);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_err_lanes <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data      <= port_data;
                rd_err_lanes <= mism;
            end
        end
    end

    assign rd_err = |rd_err_lanes;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scrub_en)  state_d = SCAN;
            SCAN:    if (!scrub_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scrub_issue = 1'b0;
        if (state_q == SCAN && !rd_en) scrub_issue = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scrub_addr <= '0;
            scrub_done <= 1'b0;
        end else begin
            scrub_done <= scrub_issue && (&scrub_addr);
            if (scrub_issue) scrub_addr <= scrub_addr + 1'b1;
        end
    end

    // A coincident err_clr loses to a new error event, which restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (err_evt) begin
            if (err_clr)            err_cnt <= CNT_W'(1);
            else if (~&err_cnt)     err_cnt <= err_cnt + 1'b1;
            if (err_clr || !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= port_addr;
            end
        end else if (err_clr) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end
    end

endmodule

// File: tb/tb_parity_mem.sv
// Scoreboard bench for parity_mem: directed writes/reads, injection, saturation, scrub passes and reset mid-pass.
module tb_parity_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int LANE_W = 4;
    localparam int CNT_W  = 2;
    localparam int NL     = DATA_W / LANE_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [NL-1:0]     inj_err = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic [NL-1:0]     rd_err_lanes;
    logic              scrub_en = 1'b0;
    logic              scrub_done;
    logic [CNT_W-1:0]  err_cnt;
    logic              first_err_valid;
    logic [ADDR_W-1:0] first_err_addr;
    logic              err_clr = 1'b0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [NL-1:0]     lanes;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [ADDR_W-1:0] tbl_a [4] = '{4'd3, 4'd2, 4'd7, 4'd9};
    logic [DATA_W-1:0] tbl_d [4] = '{8'hA5, 8'h22, 8'h3C, 8'h00};

    parity_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANE_W(LANE_W), .PARITY_ODD(0), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .inj_err         (inj_err),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_err          (rd_err),
        .rd_err_lanes    (rd_err_lanes),
        .scrub_en        (scrub_en),
        .scrub_done      (scrub_done),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every read response is matched against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_err_lanes", 32'(rd_err_lanes), 32'(e.lanes));
                chk("rd_err", 32'(rd_err), 32'(|e.lanes));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic [NL-1:0] l);
        exp_t e;
        e.data  = d;
        e.lanes = l;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [NL-1:0] inj);
        wr_en = 1'b1; wr_addr = a; wr_data = d; inj_err = inj;
        step();
        wr_en = 1'b0; inj_err = '0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [NL-1:0] l);
        rd_en = 1'b1; rd_addr = a;
        push_exp(d, l);
        step();
        rd_en = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rd_err"}, 32'(rd_err), 32'd0);
        chk({tag, "_rd_err_lanes"}, 32'(rd_err_lanes), 32'd0);
        chk({tag, "_scrub_done"}, 32'(scrub_done), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_first_err_valid"}, 32'(first_err_valid), 32'd0);
        chk({tag, "_first_err_addr"}, 32'(first_err_addr), 32'd0);
    endtask

    // Enable scrubbing and count negedges until scrub_done; optional user reads on even counts.
    task automatic run_scrub(input bit interleave, output int cyc);
        int k;
        int ri;
        k  = 0;
        ri = 0;
        scrub_en = 1'b1;
        rd_en    = 1'b0;
        while (k < 100) begin
            step();
            k++;
            if (scrub_done === 1'b1) break;
            if (interleave && (k % 2 == 0)) begin
                rd_en   = 1'b1;
                rd_addr = tbl_a[ri % 4];
                push_exp(tbl_d[ri % 4], '0);
                ri++;
            end else begin
                rd_en = 1'b0;
            end
        end
        scrub_en = 1'b0;
        rd_en    = 1'b0;
        cyc      = k;
    endtask

    initial begin
        int cyc;
        int done_seen;

        step();
        step();
        chk_reset_values("reset");
        reset = 1'b0;

        // Untouched memory reads as zero with good parity.
        do_read(4'd0, 8'h00, 2'b00);

        do_write(4'd3, 8'hA5, 2'b00);
        do_read(4'd3, 8'hA5, 2'b00);
        chk("err_cnt_clean", 32'(err_cnt), 32'd0);

        do_write(4'd7, 8'h3C, 2'b10);
        do_read(4'd7, 8'h3C, 2'b10);
        chk("inj_err_cnt", 32'(err_cnt), 32'd1);
        chk("inj_first_valid", 32'(first_err_valid), 32'd1);
        chk("inj_first_addr", 32'(first_err_addr), 32'd7);
        step();
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'h3C);
        do_read(4'd7, 8'h3C, 2'b10);
        chk("inj2_err_cnt", 32'(err_cnt), 32'd2);
        chk("inj2_first_addr", 32'(first_err_addr), 32'd7);

        // Same-cycle read and write of addr 2: read returns old data.
        do_write(4'd2, 8'h11, 2'b00);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h22;
        rd_en = 1'b1; rd_addr = 4'd2;
        push_exp(8'h11, 2'b00);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        do_read(4'd2, 8'h22, 2'b00);

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_first_valid", 32'(first_err_valid), 32'd0);
        chk("clr_first_addr", 32'(first_err_addr), 32'd0);

        for (int i = 0; i < 4; i++) do_read(4'd7, 8'h3C, 2'b10);
        chk("sat_err_cnt", 32'(err_cnt), 32'd3);
        chk("sat_first_addr", 32'(first_err_addr), 32'd7);

        do_write(4'd9, 8'h00, 2'b01);
        err_clr = 1'b1;
        do_read(4'd9, 8'h00, 2'b01);
        err_clr = 1'b0;
        chk("clr_evt_err_cnt", 32'(err_cnt), 32'd1);
        chk("clr_evt_first_valid", 32'(first_err_valid), 32'd1);
        chk("clr_evt_first_addr", 32'(first_err_addr), 32'd9);

        // Scrub pass: only addr 5 and addr 12 carry errors.
        do_write(4'd7, 8'h3C, 2'b00);
        do_write(4'd9, 8'h00, 2'b00);
        do_write(4'd5, 8'h5A, 2'b01);
        do_write(4'd12, 8'hF0, 2'b10);
        apply_reset();
        run_scrub(1'b0, cyc);
        chk("scrub_pass_cycles", 32'(cyc), 32'd17);
        chk("scrub_err_cnt", 32'(err_cnt), 32'd2);
        chk("scrub_first_addr", 32'(first_err_addr), 32'd5);
        step();
        chk("scrub_done_pulse", 32'(scrub_done), 32'd0);

        // Interleaved user reads stretch the pass to 1 + 31 cycles.
        apply_reset();
        run_scrub(1'b1, cyc);
        chk("interleave_cycles", 32'(cyc), 32'd32);
        chk("interleave_err_cnt", 32'(err_cnt), 32'd2);
        chk("interleave_first_addr", 32'(first_err_addr), 32'd5);
        step();

        // Reset mid-pass, with scrub_addr at 6 and addr 5 already counted.
        apply_reset();
        do_read(4'd3, 8'hA5, 2'b00);
        scrub_en = 1'b1;
        repeat (7) step();
        chk("midpass_err_cnt", 32'(err_cnt), 32'd1);
        reset = 1'b1;
        scrub_en = 1'b0;
        step();
        reset = 1'b0;
        chk_reset_values("midpass");
        done_seen = 0;
        repeat (20) begin
            step();
            if (scrub_done === 1'b1) done_seen++;
        end
        chk("midpass_no_done", 32'(done_seen), 32'd0);
        chk("midpass_idle_err_cnt", 32'(err_cnt), 32'd0);
        run_scrub(1'b0, cyc);
        chk("midpass_restart_cycles", 32'(cyc), 32'd17);
        chk("midpass_restart_first_addr", 32'(first_err_addr), 32'd5);
        step();

        do_read(4'd3, 8'hA5, 2'b00);
        do_read(4'd12, 8'hF0, 2'b10);
        do_read(4'd5, 8'h5A, 2'b01);
        do_read(4'd2, 8'h22, 2'b00);
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
